// File: rtl/cmp_pkg.sv
// cmp_pkg: shared state encoding and constant helpers for the serial equality compare controller.
`default_nettype none

package cmp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/eq2_slice.sv
// eq2_slice: combinational equality of two 2-bit slices.
`default_nettype none

module eq2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq
);

  assign eq = (a == b);

endmodule

`default_nettype wire

// File: rtl/serial_eq_compare_ctrl.sv
// serial_eq_compare_ctrl: walks a 2-bit equality slice across two WIDTH-bit operands, LSB slice first.
// Optional build macro EARLY_EXIT_EN ends the walk at the first mismatching slice.
`default_nettype none

module serial_eq_compare_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int NSLICE = WIDTH / 2,
  localparam int IDXW = (clog2(NSLICE) > 1) ? clog2(NSLICE) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              equals,
  output logic [IDXW-1:0]   mismatch_idx
);

  logic [1:0]       state;
  logic [IDXW-1:0]  cnt;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             eq_acc;
  logic             found;
  logic             eq_q;

  logic [1:0] a_sl [NSLICE];
  logic [1:0] b_sl [NSLICE];
  logic       slice_eq;
  logic       last_slice;
  logic       run_exit;

  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    assign a_sl[g] = a_q[2*g +: 2];
    assign b_sl[g] = b_q[2*g +: 2];
  end

  eq2_slice u_eq2_slice (
    .a  (a_sl[cnt]),
    .b  (b_sl[cnt]),
    .eq (slice_eq)
  );

  assign last_slice = (cnt == IDXW'(NSLICE - 1));

`ifdef EARLY_EXIT_EN
  assign run_exit = last_slice | ~slice_eq;
`else
  assign run_exit = last_slice;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      idx_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      eq_acc <= 1'b0;
      found  <= 1'b0;
      eq_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) begin
            a_q    <= a_in;
            b_q    <= b_in;
            cnt    <= '0;
            idx_q  <= '0;
            eq_acc <= 1'b1;
            found  <= 1'b0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          eq_acc <= eq_acc & slice_eq;
          // Latch only the first miss so the lowest slice index is reported.
          if (!slice_eq && !found) begin
            idx_q <= cnt;
            found <= 1'b1;
          end
          if (run_exit) begin
            eq_q  <= eq_acc & slice_eq;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + IDXW'(1);
          end
        end
        ST_DONE: begin
          if (result_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign start_ready  = (state == ST_IDLE);
  assign result_valid = (state == ST_DONE);
  assign equals       = eq_q;
  assign mismatch_idx = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_eq_compare_ctrl.sv
// tb_serial_eq_compare_ctrl: directed vectors with a scoreboard queue checked by an output monitor.
`default_nettype none

module tb_serial_eq_compare_ctrl;

`ifdef EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct {
    logic       eq;
    logic [1:0] idx;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       result_valid;
  logic       result_ready = 1'b1;
  logic       equals;
  logic [1:0] mismatch_idx;

  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  exp_t q[$];
  exp_t cur;
  bit   in_res = 0;
  bit   chk_after = 0;

  serial_eq_compare_ctrl #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a_in         (a_in),
    .b_in         (b_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .equals       (equals),
    .mismatch_idx (mismatch_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_for(input bit mism, input int m);
    return (EE && mism) ? (m + 1) : 4;
  endfunction

  // Monitor: samples on the falling edge, pops one expectation per result.
  always @(negedge clk) begin
    if (reset) begin
      in_res    = 0;
      chk_after = 0;
    end else begin
      if (chk_after) begin
        chk("start_ready_after_hs", int'(start_ready), 1);
        chk("result_valid_after_hs", int'(result_valid), 0);
        chk_after = 0;
      end
      if (result_valid) begin
        if (!in_res) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 1, 0);
            cur = '{eq: equals, idx: mismatch_idx, lat: 0};
          end else begin
            cur = q.pop_front();
            chk("latency", cyc - acc_cyc, cur.lat);
          end
          in_res = 1;
        end
        chk("equals", int'(equals), int'(cur.eq));
        chk("mismatch_idx", int'(mismatch_idx), int'(cur.idx));
        chk("start_ready_in_done", int'(start_ready), 0);
        if (result_ready) begin
          in_res    = 0;
          chk_after = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!start_ready && n < 40) begin
      step();
      n++;
    end
    if (!start_ready) chk({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic run_cmp(input logic [7:0] a, input logic [7:0] b, input logic e,
                         input logic [1:0] idx, input int lat, input bit hold);
    int n;
    wait_idle("pre");
    if (hold) result_ready = 1'b0;
    q.push_back('{eq: e, idx: idx, lat: lat});
    acc_cyc     = cyc + 1;
    a_in        = a;
    b_in        = b;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    a_in        = 8'h5A;
    b_in        = 8'hC3;
    if (hold) begin
      n = 0;
      while (!result_valid && n < 20) begin
        step();
        n++;
      end
      if (!result_valid) chk("hold_result_timeout", 0, 1);
      for (int i = 0; i < 5; i++) begin
        start_valid = (i < 3);
        a_in        = 8'h77;
        b_in        = 8'h77;
        step();
      end
      start_valid  = 1'b0;
      result_ready = 1'b1;
      step();
    end
    step();
    wait_idle("post");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk("reset_start_ready", int'(start_ready), 1);
    chk("reset_result_valid", int'(result_valid), 0);
    chk("reset_equals", int'(equals), 0);
    chk("reset_mismatch_idx", int'(mismatch_idx), 0);
    reset = 1'b0;
    step();

    run_cmp(8'hA5, 8'hA5, 1'b1, 2'd0, 4, 0);
    run_cmp(8'h35, 8'hB5, 1'b0, 2'd3, lat_for(1, 3), 0);
    run_cmp(8'h3C, 8'h0C, 1'b0, 2'd2, lat_for(1, 2), 0);
    run_cmp(8'h12, 8'h12, 1'b1, 2'd0, 4, 1);
    run_cmp(8'hA5, 8'hA4, 1'b0, 2'd0, lat_for(1, 0), 0);
    run_cmp(8'h00, 8'hFF, 1'b0, 2'd0, lat_for(1, 0), 0);
    run_cmp(8'h80, 8'h00, 1'b0, 2'd3, lat_for(1, 3), 0);
    run_cmp(8'h11, 8'h12, 1'b0, 2'd0, lat_for(1, 0), 0);

    // Abort a compare with reset during its second RUN cycle.
    wait_idle("pre_reset");
    a_in        = 8'hF0;
    b_in        = 8'hF0;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("abort_start_ready", int'(start_ready), 1);
    chk("abort_result_valid", int'(result_valid), 0);
    chk("abort_equals", int'(equals), 0);
    chk("abort_mismatch_idx", int'(mismatch_idx), 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step();

    run_cmp(8'h0F, 8'h0F, 1'b1, 2'd0, 4, 0);

    for (int i = 0; i < 4; i++) step();
    chk("scoreboard_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
